arbitro_barramento: RTL and testbench

Round-robin arbiter that shares the 4-bit, four-source multiplexer datapath (the 16-to-4 bus mux) among four requesters. It takes one request line per source, grants exactly one at a time, and drives the mux select pair `chave0`/`chave1` so the granted source's nibble reaches the shared output. Tenure lasts while the requester holds its request. An optional quantum preempts long holders.

---
 rtl/arbitro_pkg.sv | 20 ++
 rtl/seletor_rr.sv | 26 ++
 rtl/arbitro_barramento.sv | 110 +++++++++++
 tb/tb_arbitro_barramento.sv | 127 ++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared definitions for the round-robin bus arbiter (arbitro_barramento).
package arbitro_pkg;

  localparam int unsigned N_FONTES = 4;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic {
    LIVRE     = 1'b0,
    CONCEDIDO = 1'b1
  } estado_t;

  // Pointer starts at the last index so source 0 is searched first.
  localparam logic [SEL_W-1:0] ULTIMO_RESET = 2'd3;

  function automatic logic [N_FONTES-1:0] oneHot(input logic [SEL_W-1:0] idx);
    oneHot      = '0;
    oneHot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/seletor_rr.sv
// Combinational round-robin search: first asserted req starting at ultimo+1.
module seletor_rr
  import arbitro_pkg::*;
(
  input  logic [N_FONTES-1:0] req,
  input  logic [SEL_W-1:0]    ultimo,
  output logic                achou,
  output logic [SEL_W-1:0]    indice
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    achou  = 1'b0;
    indice = ultimo;
    cand   = '0;
    for (int unsigned k = 1; k <= N_FONTES; k++) begin
      cand = ultimo + SEL_W'(k);
      if (!achou && req[cand]) begin
        achou  = 1'b1;
        indice = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_barramento.sv
// Round-robin arbiter driving the 16-to-4 bus mux selects.
// Optional tenure quantum enabled by defining ARBITRO_QUANTUM_EN.
module arbitro_barramento
  import arbitro_pkg::*;
#(
  parameter int unsigned QUANTUM = 8
)(
  input  logic                clock,
  input  logic                reset,
  input  logic [N_FONTES-1:0] req,
  output logic [N_FONTES-1:0] grant,
  output logic                chave0,
  output logic                chave1,
  output logic                ocupado
);

  if (QUANTUM < 2 || QUANTUM > 255) begin : gQuantumFaixa
    $error("QUANTUM out of range 2..255");
  end

  estado_t             estado, estadoProx;
  logic [SEL_W-1:0]    ultimo, ultimoProx;
  logic [SEL_W-1:0]    sel, selProx;
  logic [N_FONTES-1:0] grantProx;
  logic                achou;
  logic [SEL_W-1:0]    indice;
  logic                novaConcessao;
`ifdef ARBITRO_QUANTUM_EN
  logic [7:0]          cont, contProx;
`endif

  seletor_rr uSeletor (
    .req   (req),
    .ultimo(ultimo),
    .achou (achou),
    .indice(indice)
  );

  always_comb begin
    estadoProx    = estado;
    ultimoProx    = ultimo;
    grantProx     = grant;
    selProx       = sel;
    novaConcessao = 1'b0;
`ifdef ARBITRO_QUANTUM_EN
    contProx      = cont;
`endif
    unique case (estado)
      LIVRE: begin
        if (achou) novaConcessao = 1'b1;
      end
      CONCEDIDO: begin
        // ultimo always names the current holder while CONCEDIDO.
        if (!req[ultimo]) begin
          if (achou) begin
            novaConcessao = 1'b1;
          end else begin
            estadoProx = LIVRE;
            grantProx  = '0;
          end
        end
`ifdef ARBITRO_QUANTUM_EN
        // Holder still requesting: search wraps to the holder only when nobody else waits.
        else if (cont == 8'(QUANTUM - 1)) begin
          if (indice != ultimo) novaConcessao = 1'b1;
          else                  contProx = '0;
        end else begin
          contProx = cont + 8'd1;
        end
`endif
      end
      default: ;
    endcase
    if (novaConcessao) begin
      estadoProx = CONCEDIDO;
      ultimoProx = indice;
      grantProx  = oneHot(indice);
      selProx    = indice;
`ifdef ARBITRO_QUANTUM_EN
      contProx   = '0;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado  <= LIVRE;
      ultimo  <= ULTIMO_RESET;
      grant   <= '0;
      sel     <= '0;
      ocupado <= 1'b0;
`ifdef ARBITRO_QUANTUM_EN
      cont    <= '0;
`endif
    end else begin
      estado  <= estadoProx;
      ultimo  <= ultimoProx;
      grant   <= grantProx;
      sel     <= selProx;
      ocupado <= |grantProx;
`ifdef ARBITRO_QUANTUM_EN
      cont    <= contProx;
`endif
    end
  end

  assign chave0 = sel[0];
  assign chave1 = sel[1];

endmodule

// File: tb/tb_arbitro_barramento.sv
// Self-checking bench for arbitro_barramento; quantum expectations follow ARBITRO_QUANTUM_EN.
module tb_arbitro_barramento;

  typedef struct {
    logic [3:0] req;
    logic [3:0] expGrant;
    logic [1:0] expSel;
  } vetor_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req   = '0;
  logic [3:0] grant;
  logic       chave0, chave1, ocupado;

  int checks   = 0;
  int failures = 0;

  vetor_t tabela[$];
  vetor_t esperado[$];

  arbitro_barramento #(.QUANTUM(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .grant  (grant),
    .chave0 (chave0),
    .chave1 (chave1),
    .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  function automatic void add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s);
    vetor_t v;
    v.req = r; v.expGrant = g; v.expSel = s;
    tabela.push_back(v);
  endfunction

  task automatic verifica(input string nome, input logic [3:0] g, input logic [1:0] s);
    logic [6:0] got, exp;
    got = {grant, chave1, chave0, ocupado};
    exp = {g, s, |g};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got grant=%b chave=%b ocupado=%b, expected grant=%b chave=%b ocupado=%b",
               nome, $time, got[6:3], got[2:1], got[0], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic aplica(input vetor_t v, input string nome);
    vetor_t e;
    @(negedge clock);
    req = v.req;
    esperado.push_back(v);
    @(posedge clock);
    #1;
    e = esperado.pop_front();
    verifica(nome, e.expGrant, e.expSel);
  endtask

  initial begin
    // rotation from reset, then idle with select held
    add(4'b1111, 4'b0001, 2'b00);
    add(4'b1110, 4'b0010, 2'b01);
    add(4'b1101, 4'b0100, 2'b10);
    add(4'b1011, 4'b1000, 2'b11);
    add(4'b0111, 4'b0001, 2'b00);
    add(4'b0000, 4'b0000, 2'b00);
    // single requester for 5 cycles, then release
    for (int i = 0; i < 5; i++) add(4'b0100, 4'b0100, 2'b10);
    add(4'b0000, 4'b0000, 2'b10);
    // others never disturb holder; priority after service
    add(4'b0100, 4'b0100, 2'b10);
    add(4'b0101, 4'b0100, 2'b10);
    add(4'b1101, 4'b0100, 2'b10);
    add(4'b0001, 4'b0001, 2'b00);
    add(4'b0000, 4'b0000, 2'b00);
    add(4'b0100, 4'b0100, 2'b10);
    add(4'b0011, 4'b0001, 2'b00);
    add(4'b0010, 4'b0010, 2'b01);
    add(4'b0000, 4'b0000, 2'b01);
    // source 1 holds, source 3 joins at cycle 2
    add(4'b0010, 4'b0010, 2'b01);
    for (int i = 0; i < 3; i++) add(4'b1010, 4'b0010, 2'b01);
`ifdef ARBITRO_QUANTUM_EN
    add(4'b1010, 4'b1000, 2'b11);
    add(4'b1010, 4'b1000, 2'b11);
`else
    add(4'b1010, 4'b0010, 2'b01);
    add(4'b1010, 4'b0010, 2'b01);
`endif
    add(4'b1000, 4'b1000, 2'b11);
    add(4'b0000, 4'b0000, 2'b11);
    // lone holder is never preempted
    for (int i = 0; i < 10; i++) add(4'b0010, 4'b0010, 2'b01);
    add(4'b0000, 4'b0000, 2'b01);

    #1 reset = 1'b1;
    #1 verifica("reset_inicial", 4'b0000, 2'b00);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tabela.size(); i++)
      aplica(tabela[i], $sformatf("vetor_%0d", i));

    // asynchronous reset mid-tenure
    begin
      vetor_t v;
      v.req = 4'b1111; v.expGrant = 4'b0100; v.expSel = 2'b10;
      aplica(v, "pre_reset");
    end
    #2 reset = 1'b1;
    #1 verifica("reset_assincrono", 4'b0000, 2'b00);
    @(negedge clock);
    verifica("reset_mantido", 4'b0000, 2'b00);
    reset = 1'b0;
    @(posedge clock);
    #1 verifica("pos_reset", 4'b0001, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
